multi_step_vault_ctrl: RTL

//  Parametrised multi-step combination vault controller. Drop-in successor of
//  the single-number vault FSM. Takes a NUM_STEPS combination dialled with

---
 rtl/multi_step_vault_ctrl.sv | 158 +++++++++++++++
 1 files changed

// File: rtl/multi_step_vault_ctrl.sv
// Multi-step combination vault controller: alternating-direction combination entry,
// consecutive-failure counting and a timed lockout.
//
// state     | meaning
// ----------+----------------------------------------------------------
// LOCKED    | idle, waiting for dial turned down to 0 to start an attempt
// STARTED   | combination latched, waiting for the first upward movement
// SEEK      | moving towards entry [step] in direction dir_k
// ARMED     | dial resting on entry [step], waiting for direction reversal
// UNLOCKED  | combination accepted, lock open while dial turns up
// RELOCK    | dial turned down after unlock, waiting for dial at 0
// LOCKOUT   | too many failures, inputs ignored until timer expires
module multi_step_vault_ctrl #(
  parameter int CODE_W         = 5,
  parameter int NUM_STEPS      = 3,
  parameter int MAX_FAILS      = 3,
  parameter int LOCKOUT_CYCLES = 16,
  localparam int STEP_W = (NUM_STEPS > 1) ? $clog2(NUM_STEPS) : 1,
  localparam int FC_W   = $clog2(MAX_FAILS + 1),
  localparam int TMR_W  = (LOCKOUT_CYCLES > 1) ? $clog2(LOCKOUT_CYCLES) : 1
) (
  input  logic                        clock,
  input  logic                        n_reset,
  input  logic                        direction,
  input  logic [CODE_W-1:0]           vault_code,
  input  logic [NUM_STEPS*CODE_W-1:0] combo,
  output logic                        unlocked,
  output logic                        lockout,
  output logic [STEP_W-1:0]           step,
  output logic [FC_W-1:0]             fail_cnt,
  output logic [9:0]                  led
);

  typedef enum logic [2:0] {
    S_LOCKED, S_STARTED, S_SEEK, S_ARMED, S_UNLOCKED, S_RELOCK, S_LOCKOUT
  } state_t;

  state_t                      state, state_n;
  logic [STEP_W-1:0]           step_n;
  logic [FC_W-1:0]             fail_cnt_n;
  logic [TMR_W-1:0]            timer, timer_n;
  logic [NUM_STEPS*CODE_W-1:0] combo_q, combo_q_n;

  logic [CODE_W-1:0] cur_code;
  logic              dir_k, hit, past, last, do_fail;

  always_comb begin
    cur_code = '0;
    for (int k = 0; k < NUM_STEPS; k++)
      if (step == STEP_W'(k)) cur_code = combo_q[k*CODE_W +: CODE_W];
  end

  // even entries are approached turning up, odd entries turning down
  assign dir_k = ~step[0];
  assign hit   = (vault_code == cur_code);
  assign past  = dir_k ? (vault_code > cur_code) : (vault_code < cur_code);
  assign last  = (step == STEP_W'(NUM_STEPS - 1));

  always_ff @(posedge clock or negedge n_reset) begin
    if (!n_reset) begin
      state    <= S_LOCKED;
      step     <= '0;
      fail_cnt <= '0;
      timer    <= '0;
      combo_q  <= '0;
    end else begin
      state    <= state_n;
      step     <= step_n;
      fail_cnt <= fail_cnt_n;
      timer    <= timer_n;
      combo_q  <= combo_q_n;
    end
  end

  always_comb begin
    state_n    = state;
    step_n     = step;
    fail_cnt_n = fail_cnt;
    timer_n    = timer;
    combo_q_n  = combo_q;
    do_fail    = 1'b0;
    case (state)
      S_LOCKED: begin
        if (!direction && vault_code == '0) begin
          state_n   = S_STARTED;
          combo_q_n = combo;
          step_n    = '0;
        end
      end
      S_STARTED: begin
        if (direction && vault_code != '0) state_n = S_SEEK;
      end
      S_SEEK: begin
        if (direction == dir_k && hit) begin
          if (last) begin
            state_n    = S_UNLOCKED;
            fail_cnt_n = '0;
          end else begin
            state_n = S_ARMED;
          end
        end else if (direction != dir_k || past) begin
          do_fail = 1'b1;
        end
      end
      S_ARMED: begin
        if (direction != dir_k) begin
          step_n  = step + STEP_W'(1);
          state_n = S_SEEK;
        end else if (!hit) begin
          do_fail = 1'b1;
        end
      end
      S_UNLOCKED: begin
        if (!direction) state_n = S_RELOCK;
      end
      S_RELOCK: begin
        if (!direction && vault_code == '0) begin
          state_n = S_LOCKED;
          step_n  = '0;
        end
      end
      S_LOCKOUT: begin
        if (timer == '0) begin
          state_n    = S_LOCKED;
          fail_cnt_n = '0;
        end else begin
          timer_n = timer - TMR_W'(1);
        end
      end
      default: state_n = S_LOCKED;
    endcase

    if (do_fail) begin
      step_n = '0;
      if (fail_cnt == FC_W'(MAX_FAILS - 1)) begin
        state_n = S_LOCKOUT;
        timer_n = TMR_W'(LOCKOUT_CYCLES - 1);
      end else begin
        state_n    = S_LOCKED;
        fail_cnt_n = fail_cnt + FC_W'(1);
      end
    end
  end

  assign unlocked = (state == S_UNLOCKED);
  assign lockout  = (state == S_LOCKOUT);

  always_comb begin
    led      = '0;
    led[0]   = (state == S_LOCKED);
    led[1]   = (state == S_STARTED);
    led[2]   = (state == S_SEEK) || (state == S_ARMED);
    led[3]   = (state == S_UNLOCKED);
    led[4]   = direction;
    led[9:5] = 5'(vault_code);
  end

endmodule
